// File: rtl/gcd_pkg.sv
// Shared types and constants for the subtract-and-compare GCD engine.
package gcd_pkg;

    localparam int GCD_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CALC    = 2'd1,
        ST_DONE    = 2'd2,
        ST_ILLEGAL = 2'd3
    } gcd_state_e;

endpackage : gcd_pkg

// File: rtl/gcd_sub.sv
// W-bit combinational unsigned subtractor; callers guarantee x_i >= y_i.
module gcd_sub
    import gcd_pkg::*;
#(
    parameter int W = GCD_W
) (
    input  logic [W-1:0] x_i,
    input  logic [W-1:0] y_i,
    output logic [W-1:0] diff_o
);

    assign diff_o = x_i - y_i;

endmodule : gcd_sub

// File: rtl/gcd_engine.sv
// Sequential GCD core: repeatedly replaces the larger operand with the
// difference until the operands match or one of them is zero.
module gcd_engine
    import gcd_pkg::*;
#(
    parameter int W = GCD_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] b_in,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] gcd_out,
    output logic [W-1:0] steps
);

    gcd_state_e   state_q, state_d;
    logic [W-1:0] x_q, x_d;
    logic [W-1:0] y_q, y_d;
    logic [W-1:0] gcd_q, gcd_d;
    logic [W-1:0] steps_q, steps_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    logic         gt_s;
    logic         eq_s;
    logic         any_zero_s;
    logic [W-1:0] minuend_s;
    logic [W-1:0] subtrahend_s;
    logic [W-1:0] diff_s;

    // Comparator and operand steering: the larger operand is always the minuend.
    always_comb begin
        gt_s         = (x_q > y_q);
        eq_s         = (x_q == y_q);
        any_zero_s   = (x_q == {W{1'b0}}) || (y_q == {W{1'b0}});
        if (gt_s) begin
            minuend_s    = x_q;
            subtrahend_s = y_q;
        end else begin
            minuend_s    = y_q;
            subtrahend_s = x_q;
        end
    end

    gcd_sub #(
        .W (W)
    ) u_sub (
        .x_i    (minuend_s),
        .y_i    (subtrahend_s),
        .diff_o (diff_s)
    );

    // Next-state and datapath update logic.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        gcd_d   = gcd_q;
        steps_d = steps_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    x_d     = a_in;
                    y_d     = b_in;
                    steps_d = {W{1'b0}};
                    state_d = ST_CALC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                // A zero operand ends the job first so gcd(0,n)=n and gcd(0,0)=0.
                if (any_zero_s) begin
                    gcd_d   = x_q | y_q;
                    state_d = ST_DONE;
                end else if (eq_s) begin
                    gcd_d   = x_q;
                    state_d = ST_DONE;
                end else if (gt_s) begin
                    x_d     = diff_s;
                    steps_d = steps_q + {{(W-1){1'b0}}, 1'b1};
                end else begin
                    y_d     = diff_s;
                    steps_d = steps_q + {{(W-1){1'b0}}, 1'b1};
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Status outputs are registered from the state being entered.
    always_comb begin
        busy_d = 1'b0;
        done_d = 1'b0;
        if (state_d == ST_CALC) begin
            busy_d = 1'b1;
        end else if (state_d == ST_DONE) begin
            done_d = 1'b1;
        end else begin
            busy_d = 1'b0;
            done_d = 1'b0;
        end
    end

    // State, operand and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            x_q     <= {W{1'b0}};
            y_q     <= {W{1'b0}};
            gcd_q   <= {W{1'b0}};
            steps_q <= {W{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            gcd_q   <= gcd_d;
            steps_q <= steps_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign gcd_out = gcd_q;
    assign steps   = steps_q;

endmodule : gcd_engine

// File: tb/tb_gcd_engine.sv
// Self-checking bench for gcd_engine: directed scenarios, random jobs and a
// full 4-bit operand sweep against a Euclid-based reference model.
module tb_gcd_engine;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] a_in;
    logic [3:0] b_in;
    logic       busy;
    logic       done;
    logic [3:0] gcd_out;
    logic [3:0] steps;

    int n_cmp = 0;
    int n_bad = 0;

    gcd_engine #(.W(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a_in    (a_in),
        .b_in    (b_in),
        .busy    (busy),
        .done    (done),
        .gcd_out (gcd_out),
        .steps   (steps)
    );

    always #5 clk = ~clk;

    // Reference: gcd by Euclid's remainder rule; the number of subtractions
    // equals the sum of the Euclid quotients minus one (the final equal step).
    function automatic void ref_gcd(input int a, input int b, output int g, output int s);
        int x, y, t, qsum;
        if (a == 0 || b == 0) begin
            g = a + b;
            s = 0;
        end else begin
            x = a; y = b; qsum = 0;
            while (y != 0) begin
                qsum += x / y;
                t = x % y;
                x = y;
                y = t;
            end
            g = x;
            s = qsum - 1;
        end
    endfunction

    // Issues one job from an IDLE negedge and observes it until one cycle
    // past done. Returns at the negedge after that, with the DUT in IDLE.
    task automatic run_job(input logic [3:0] a, input logic [3:0] b,
                           output int lat, output int dcnt, output int bcnt,
                           output logic [3:0] g, output logic [3:0] s, output bit stable);
        start = 1'b1; a_in = a; b_in = b;
        @(negedge clk);
        start = 1'b0; a_in = 4'($urandom); b_in = 4'($urandom);
        lat = -1; dcnt = 0; bcnt = 0; g = 4'd0; s = 4'd0; stable = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (busy) bcnt++;
            if (done) dcnt++;
            if (done && lat < 0) begin
                lat = k; g = gcd_out; s = steps;
            end
            if (lat >= 0 && k == lat + 1) begin
                stable = (gcd_out === g) && (steps === s);
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; a_in = 4'd5; b_in = 4'd3;
        repeat (3) @(negedge clk);
        n_cmp++; if (busy !== 1'b0)    begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0)    begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (gcd_out !== 4'd0) begin n_bad++; $display("FAIL reset_gcd: got %0d want 0", gcd_out); end
        n_cmp++; if (steps !== 4'd0)   begin n_bad++; $display("FAIL reset_steps: got %0d want 0", steps); end
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0)    begin n_bad++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
    endtask

    // Directed jobs with hand-derived results: {a, b, gcd, steps}.
    task automatic test_directed();
        int tbl [5][4] = '{'{12, 8, 4, 2}, '{15, 1, 1, 14}, '{0, 9, 9, 0},
                           '{0, 0, 0, 0},  '{7, 7, 7, 0}};
        int lat, dcnt, bcnt;
        logic [3:0] g, s;
        bit stable;
        for (int i = 0; i < 5; i++) begin
            run_job(4'(tbl[i][0]), 4'(tbl[i][1]), lat, dcnt, bcnt, g, s, stable);
            n_cmp++; if (g !== 4'(tbl[i][2])) begin n_bad++; $display("FAIL dir_gcd(%0d,%0d): got %0d want %0d", tbl[i][0], tbl[i][1], g, tbl[i][2]); end
            n_cmp++; if (s !== 4'(tbl[i][3])) begin n_bad++; $display("FAIL dir_steps(%0d,%0d): got %0d want %0d", tbl[i][0], tbl[i][1], s, tbl[i][3]); end
            n_cmp++; if (lat != tbl[i][3] + 1) begin n_bad++; $display("FAIL dir_latency(%0d,%0d): got %0d want %0d", tbl[i][0], tbl[i][1], lat, tbl[i][3] + 1); end
            n_cmp++; if (bcnt != tbl[i][3] + 1) begin n_bad++; $display("FAIL dir_busy_cycles(%0d,%0d): got %0d want %0d", tbl[i][0], tbl[i][1], bcnt, tbl[i][3] + 1); end
            n_cmp++; if (dcnt != 1) begin n_bad++; $display("FAIL dir_done_count(%0d,%0d): got %0d want 1", tbl[i][0], tbl[i][1], dcnt); end
        end
    endtask

    task automatic test_spurious_start();
        int eg, es, lat;
        ref_gcd(9, 6, eg, es);
        lat = -1;
        start = 1'b1; a_in = 4'd9; b_in = 4'd6;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; a_in = 4'd5; b_in = 4'd5;
        @(negedge clk);
        start = 1'b0;
        for (int k = 2; k < 40 && lat < 0; k++) begin
            if (done) lat = k;
            else @(negedge clk);
        end
        n_cmp++; if (lat != es + 1) begin n_bad++; $display("FAIL spur_latency: got %0d want %0d", lat, es + 1); end
        n_cmp++; if (gcd_out !== 4'(eg)) begin n_bad++; $display("FAIL spur_gcd: got %0d want %0d", gcd_out, eg); end
        n_cmp++; if (steps !== 4'(es)) begin n_bad++; $display("FAIL spur_steps: got %0d want %0d", steps, es); end
        // A start raised during the done cycle must also be ignored.
        start = 1'b1; a_in = 4'd1; b_in = 4'd1;
        @(negedge clk);
        start = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL spur_done_start_busy: got %b want 0", busy); end
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL spur_done_start_idle: got %b want 0", busy); end
        n_cmp++; if (gcd_out !== 4'(eg)) begin n_bad++; $display("FAIL spur_gcd_hold: got %0d want %0d", gcd_out, eg); end
    endtask

    task automatic test_back_to_back();
        int lat, dcnt, bcnt, eg, es;
        logic [3:0] g, s;
        bit stable;
        run_job(4'd9, 4'd6, lat, dcnt, bcnt, g, s, stable);
        run_job(4'd10, 4'd4, lat, dcnt, bcnt, g, s, stable);
        ref_gcd(10, 4, eg, es);
        n_cmp++; if (g !== 4'(eg)) begin n_bad++; $display("FAIL b2b_gcd: got %0d want %0d", g, eg); end
        n_cmp++; if (s !== 4'(es)) begin n_bad++; $display("FAIL b2b_steps: got %0d want %0d", s, es); end
        n_cmp++; if (lat != es + 1) begin n_bad++; $display("FAIL b2b_latency: got %0d want %0d", lat, es + 1); end
        n_cmp++; if (dcnt != 1) begin n_bad++; $display("FAIL b2b_done_count: got %0d want 1", dcnt); end
    endtask

    task automatic test_reset_mid_job();
        int seen_done, lat, dcnt, bcnt;
        logic [3:0] g, s;
        bit stable;
        seen_done = 0;
        start = 1'b1; a_in = 4'd15; b_in = 4'd1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (done) seen_done++;
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        if (done) seen_done++;
        n_cmp++; if (seen_done != 0) begin n_bad++; $display("FAIL rstmid_no_done: got %0d pulses want 0", seen_done); end
        n_cmp++; if (busy !== 1'b0)    begin n_bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        n_cmp++; if (gcd_out !== 4'd0) begin n_bad++; $display("FAIL rstmid_gcd: got %0d want 0", gcd_out); end
        n_cmp++; if (steps !== 4'd0)   begin n_bad++; $display("FAIL rstmid_steps: got %0d want 0", steps); end
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL rstmid_idle: got busy=%b done=%b want 0 0", busy, done); end
        run_job(4'd6, 4'd4, lat, dcnt, bcnt, g, s, stable);
        n_cmp++; if (g !== 4'd2) begin n_bad++; $display("FAIL rstmid_next_gcd: got %0d want 2", g); end
    endtask

    task automatic test_random_gaps();
        int lat, dcnt, bcnt, eg, es, a, b, gap;
        logic [3:0] g, s;
        bit stable;
        for (int i = 0; i < 30; i++) begin
            a = int'($urandom_range(15, 0));
            b = int'($urandom_range(15, 0));
            run_job(4'(a), 4'(b), lat, dcnt, bcnt, g, s, stable);
            ref_gcd(a, b, eg, es);
            n_cmp++; if (g !== 4'(eg) || s !== 4'(es)) begin n_bad++; $display("FAIL rand(%0d,%0d): got gcd=%0d steps=%0d want gcd=%0d steps=%0d", a, b, g, s, eg, es); end
            gap = int'($urandom_range(3, 0));
            for (int j = 0; j < gap; j++) begin
                a_in = 4'($urandom); b_in = 4'($urandom);
                @(negedge clk);
            end
            n_cmp++; if (gcd_out !== g || steps !== s || busy !== 1'b0) begin n_bad++; $display("FAIL rand_idle_hold(%0d,%0d): got gcd=%0d steps=%0d busy=%b want gcd=%0d steps=%0d busy=0", a, b, gcd_out, steps, busy, g, s); end
        end
    endtask

    task automatic test_sweep();
        int lat, dcnt, bcnt, eg, es;
        logic [3:0] g, s;
        bit stable;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_job(4'(a), 4'(b), lat, dcnt, bcnt, g, s, stable);
                ref_gcd(a, b, eg, es);
                n_cmp++; if (g !== 4'(eg)) begin n_bad++; $display("FAIL sweep_gcd(%0d,%0d): got %0d want %0d", a, b, g, eg); end
                n_cmp++; if (s !== 4'(es)) begin n_bad++; $display("FAIL sweep_steps(%0d,%0d): got %0d want %0d", a, b, s, es); end
                n_cmp++; if (lat != es + 1) begin n_bad++; $display("FAIL sweep_latency(%0d,%0d): got %0d want %0d", a, b, lat, es + 1); end
                n_cmp++; if (bcnt != es + 1) begin n_bad++; $display("FAIL sweep_busy(%0d,%0d): got %0d want %0d", a, b, bcnt, es + 1); end
                n_cmp++; if (dcnt != 1) begin n_bad++; $display("FAIL sweep_done_count(%0d,%0d): got %0d want 1", a, b, dcnt); end
                n_cmp++; if (!stable) begin n_bad++; $display("FAIL sweep_hold(%0d,%0d): got gcd=%0d steps=%0d want gcd=%0d steps=%0d", a, b, gcd_out, steps, g, s); end
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a_in = 4'd0; b_in = 4'd0;
        @(negedge clk);
        test_reset();
        test_directed();
        test_spurious_start();
        test_back_to_back();
        test_reset_mid_job();
        test_random_gaps();
        test_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_gcd_engine
